// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and enums for the sprite RAM loader
//
// Purpose: sprite RAM geometry, palette limit, reserved sprite indices,
//          loader FSM state encoding and error code encoding.
// Ports:   none (package).
package sprite_pkg;

  localparam int ADDR_W      = 11;
  localparam int DEPTH       = 1707;
  localparam int MAX_PALETTE = 31;

  // Reserved words at the top of sprite RAM used by the colour mapper.
  localparam int IDX_BG      = 1704;
  localparam int IDX_TERRAIN = 1705;
  localparam int IDX_BLANK   = 1706;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GET_COUNT,
    ST_GET_PIXEL,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_BYTE  = 2'd2,
    ERR_LEN   = 2'd3
  } err_code_t;

endpackage

// File: rtl/rle_run_counter.sv
// rtl/rle_run_counter.sv - expands one RLE run into consecutive RAM writes
//
// Purpose: holds the next write address and the pixels left in the load
//          window; on load, emits one registered write per cycle for the
//          run length and flags the last write of the run / window.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   init                load window start address and pixel count
//   init_addr           first address of the window
//   init_remaining      pixel count of the window
//   load                start a run (first write appears next cycle)
//   run, palette        run length (>=1) and palette index for this run
//   we, write_address,
//   data_in             registered RAM write port
//   remaining           pixels still unwritten in the window
//   run_end             current write is the last of the run
//   load_end            window fully written (valid alongside run_end)
module rle_run_counter
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W:0]   init_remaining,
  input  logic              load,
  input  logic [7:0]        run,
  input  logic [7:0]        palette,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        data_in,
  output logic [ADDR_W:0]   remaining,
  output logic              run_end,
  output logic              load_end
);

  logic [ADDR_W-1:0] addr;
  logic [7:0]        run_left;
  logic              step;

  // A write is issued on the load cycle and then while the run has pixels left.
  assign step     = load | (we & (run_left != 8'd0));
  assign run_end  = we & (run_left == 8'd0);
  assign load_end = (remaining == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we            <= 1'b0;
      write_address <= '0;
      data_in       <= 8'd0;
      addr          <= '0;
      remaining     <= '0;
      run_left      <= 8'd0;
    end else begin
      we <= step;
      if (init) begin
        addr      <= init_addr;
        remaining <= init_remaining;
      end else if (step) begin
        write_address <= addr;
        addr          <= addr + ADDR_W'(1);
        remaining     <= remaining - (ADDR_W+1)'(1);
      end
      // run_left counts writes still to come after the one being issued.
      if (load) begin
        run_left <= run - 8'd1;
        data_in  <= palette;
      end else if (step) begin
        run_left <= run_left - 8'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_ram_loader.sv
// rtl/sprite_ram_loader.sv - RLE byte stream to sprite RAM write-port loader
//
// Purpose: accepts (count, palette) byte pairs over valid/ready and expands
//          them into single-cycle writes into a caller-chosen address window.
// Ports:
//   clk, reset_n      pixel clock, asynchronous active-low reset
//   start             load request, honoured only when idle
//   base_addr, length load window (length 0..DEPTH pixels)
//   in_data, in_valid,
//   in_last, in_ready stream of alternating count/palette bytes
//   we, write_address,
//   data_in           sprite RAM write port
//   busy, done        run in progress / one-cycle success pulse
//   err_code          0 none, 1 range, 2 bad byte, 3 length mismatch (sticky)
module sprite_ram_loader
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        data_in,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  loader_state_t state, state_nx;
  logic [1:0]        err_nx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [7:0]        run_q;
  logic              pair_last;
  logic              xfer;
  logic              cnt_init, cnt_load;
  logic [ADDR_W:0]   remaining;
  logic              run_end, load_end;
  logic [ADDR_W+1:0] end_sum;
  logic [ADDR_W:0]   run_ext;

  assign xfer    = in_valid & in_ready;
  assign end_sum = {2'b00, base_q} + {1'b0, len_q};
  assign run_ext = {{(ADDR_W-7){1'b0}}, run_q};

  rle_run_counter u_counter (
    .clk            (clk),
    .reset_n        (reset_n),
    .init           (cnt_init),
    .init_addr      (base_q),
    .init_remaining (len_q),
    .load           (cnt_load),
    .run            (run_q),
    .palette        (in_data),
    .we             (we),
    .write_address  (write_address),
    .data_in        (data_in),
    .remaining      (remaining),
    .run_end        (run_end),
    .load_end       (load_end)
  );

  always_comb begin
    state_nx = state;
    err_nx   = err_code;
    cnt_init = 1'b0;
    cnt_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_CHECK;
          err_nx   = ERR_NONE;
        end
      end
      ST_CHECK: begin
        if (end_sum > (ADDR_W+2)'(DEPTH)) begin
          state_nx = ST_ERROR;
          err_nx   = ERR_RANGE;
        end else if (len_q == '0) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_GET_COUNT;
          cnt_init = 1'b1;
        end
      end
      ST_GET_COUNT: begin
        if (xfer) begin
          if (in_data == 8'd0) begin
            state_nx = ST_ERROR;
            err_nx   = ERR_BYTE;
          end else if (in_last) begin
            state_nx = ST_ERROR;
            err_nx   = ERR_LEN;
          end else begin
            state_nx = ST_GET_PIXEL;
          end
        end
      end
      ST_GET_PIXEL: begin
        if (xfer) begin
          if (in_data > 8'(MAX_PALETTE)) begin
            state_nx = ST_ERROR;
            err_nx   = ERR_BYTE;
          end else if (run_ext > remaining) begin
            state_nx = ST_ERROR;
            err_nx   = ERR_LEN;
          end else begin
            state_nx = ST_WRITE;
            cnt_load = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // The window must end exactly on the pair that carried in_last.
        if (run_end) begin
          if (load_end == pair_last) begin
            state_nx = load_end ? ST_DONE : ST_GET_COUNT;
          end else begin
            state_nx = ST_ERROR;
            err_nx   = ERR_LEN;
          end
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      ST_ERROR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      err_code  <= 2'd0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      run_q     <= 8'd0;
      pair_last <= 1'b0;
    end else begin
      state    <= state_nx;
      err_code <= err_nx;
      in_ready <= (state_nx == ST_GET_COUNT) || (state_nx == ST_GET_PIXEL);
      busy     <= (state_nx == ST_CHECK) || (state_nx == ST_GET_COUNT) ||
                  (state_nx == ST_GET_PIXEL) || (state_nx == ST_WRITE);
      done     <= (state_nx == ST_DONE);
      if (state == ST_IDLE && start) begin
        base_q <= base_addr;
        len_q  <= length;
      end
      if (state == ST_GET_COUNT && xfer) run_q <= in_data;
      if (state == ST_GET_PIXEL && xfer) pair_last <= in_last;
    end
  end

endmodule
